// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: arbiter FSM states and pipeline stall vector constants.
package mem_bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, DATA_BUSY, IF_BUSY, DONE} state_e;
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one Wishbone bus between fetch and data ports, data first.
// Optional bus watchdog enabled by defining BUS_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_done_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  input  logic [3:0]        data_sel_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_done_o,
  output logic              data_err_o,
  output logic              bus_cyc_o,
  output logic              bus_stb_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [3:0]        bus_sel_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic [5:0]        stall_o
);
  state_e            state_q, state_d;
  logic              own_data_q, own_data_d, flush_q, flush_d, err_q, err_d;
  logic              cyc_q, cyc_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, data_rdata_q, data_rdata_d;
  logic [3:0]        sel_q, sel_d;
  logic              busy, tmo;
  assign busy = (state_q == DATA_BUSY) || (state_q == IF_BUSY);
`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  assign tmo = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= busy ? cnt_q + 1'b1 : '0;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d      = state_q;
    own_data_d   = own_data_q;
    flush_d      = flush_q;
    err_d        = err_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    if_rdata_d   = if_rdata_q;
    data_rdata_d = data_rdata_q;
    case (state_q)
      IDLE: begin
        flush_d = 1'b0;
        err_d   = 1'b0;
        if (data_req_i) begin
          state_d    = DATA_BUSY;
          own_data_d = 1'b1;
          cyc_d      = 1'b1;
          we_d       = data_we_i;
          addr_d     = data_addr_i;
          wdata_d    = data_wdata_i;
          sel_d      = data_sel_i;
        end else if (if_req_i && !if_flush_i) begin
          state_d    = IF_BUSY;
          own_data_d = 1'b0;
          cyc_d      = 1'b1;
          we_d       = 1'b0;
          addr_d     = if_addr_i;
          wdata_d    = '0;
          sel_d      = 4'hF;
        end
      end
      DATA_BUSY, IF_BUSY: begin
        flush_d = flush_q | ((state_q == IF_BUSY) & if_flush_i);
        if (bus_ack_i || tmo) begin
          state_d = DONE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          sel_d   = '0;
          err_d   = !bus_ack_i;
          // a timed-out fetch returns a NOP; a timed-out data read keeps old data
          if (own_data_q) data_rdata_d = bus_ack_i ? bus_rdata_i : data_rdata_q;
          else            if_rdata_d   = bus_ack_i ? bus_rdata_i : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= IDLE;
      own_data_q   <= 1'b0;
      flush_q      <= 1'b0;
      err_q        <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      if_rdata_q   <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      own_data_q   <= own_data_d;
      flush_q      <= flush_d;
      err_q        <= err_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      if_rdata_q   <= if_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  assign bus_cyc_o    = cyc_q;
  assign bus_stb_o    = cyc_q;
  assign bus_we_o     = we_q;
  assign bus_addr_o   = addr_q;
  assign bus_wdata_o  = wdata_q;
  assign bus_sel_o    = sel_q;
  assign if_rdata_o   = if_rdata_q;
  assign data_rdata_o = data_rdata_q;
  assign data_done_o  = (state_q == DONE) && own_data_q;
  assign if_done_o    = (state_q == DONE) && !own_data_q && !flush_q;
`ifdef BUS_TIMEOUT_EN
  assign data_err_o   = data_done_o && err_q;
`else
  assign data_err_o   = 1'b0;
`endif
  // reset forces the stall vector low even while requests are still held
  assign stall_o = rst ? STALL_NONE :
                   (data_req_i && !data_done_o) ? STALL_MEM :
                   (if_req_i && !if_done_o && !if_flush_i) ? STALL_IF : STALL_NONE;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of arbitration, flush, reset, back-to-back and timeout.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req_i = 1'b0, if_flush_i = 1'b0, data_req_i = 1'b0, data_we_i = 1'b0, bus_ack_i = 1'b0;
  logic [31:0] if_addr_i = '0, data_addr_i = '0, data_wdata_i = '0, bus_rdata_i = '0;
  logic [3:0]  data_sel_i = '0;
  logic [31:0] if_rdata_o, data_rdata_o, bus_addr_o, bus_wdata_o;
  logic        if_done_o, data_done_o, data_err_o, bus_cyc_o, bus_stb_o, bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [5:0]  stall_o;
  int          errors = 0, checks = 0;
  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_rdata_o(if_rdata_o), .if_done_o(if_done_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_sel_i(data_sel_i),
    .data_rdata_o(data_rdata_o), .data_done_o(data_done_o), .data_err_o(data_err_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .stall_o(stall_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    chk("rst_cyc", bus_cyc_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_done", {if_done_o, data_done_o, data_err_o}, 0);
    chk("rst_rdata", {if_rdata_o, data_rdata_o}, 0);
    tick(); rst = 1'b0;
    tick();
    // 1: fetch read, ack on second busy cycle
    if_req_i = 1'b1; if_addr_i = 32'h100; #1;
    chk("t1_stall_idle", stall_o, 6'b000111);
    tick();
    chk("t1_cyc", {bus_cyc_o, bus_stb_o, bus_we_o}, 3'b110);
    chk("t1_addr", bus_addr_o, 32'h100);
    tick();
    chk("t1_stall_busy", stall_o, 6'b000111);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h34010001;
    tick(); bus_ack_i = 1'b0; #1;
    chk("t1_done", {if_done_o, data_done_o}, 2'b10);
    chk("t1_rdata", if_rdata_o, 32'h34010001);
    chk("t1_cyc_drop", bus_cyc_o, 0);
    chk("t1_stall_done", stall_o, 0);
    if_req_i = 1'b0;
    tick();
    chk("t1_done_pulse", if_done_o, 0);
    // 2: simultaneous requests, data write wins
    if_req_i = 1'b1; if_addr_i = 32'h104;
    data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h200;
    data_wdata_i = 32'hDEADBEEF; data_sel_i = 4'hF;
    tick();
    chk("t2_we", {bus_cyc_o, bus_we_o}, 2'b11);
    chk("t2_addr", bus_addr_o, 32'h200);
    chk("t2_wdata", bus_wdata_o, 32'hDEADBEEF);
    chk("t2_sel", bus_sel_o, 4'hF);
    chk("t2_stall", stall_o, 6'b011111);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hAAAA0000;
    tick(); bus_ack_i = 1'b0;
    chk("t2_ddone", {data_done_o, if_done_o, data_err_o}, 3'b100);
    data_req_i = 1'b0; data_we_i = 1'b0; #1;
    chk("t2_stall_if", stall_o, 6'b000111);
    tick();
    chk("t2_idle_nodone", {data_done_o, if_done_o}, 0);
    tick();
    chk("t2_if_addr", {bus_cyc_o, bus_we_o, bus_addr_o}, {2'b10, 32'h104});
    bus_ack_i = 1'b1; bus_rdata_i = 32'h11112222;
    tick(); bus_ack_i = 1'b0;
    chk("t2_idone", {data_done_o, if_done_o}, 2'b01);
    chk("t2_irdata", if_rdata_o, 32'h11112222);
    chk("t2_drdata_hold", data_rdata_o, 32'hAAAA0000);
    if_req_i = 1'b0;
    tick();
    // 3: flush during fetch
    if_req_i = 1'b1; if_addr_i = 32'h108;
    tick();
    if_flush_i = 1'b1; #1;
    chk("t3_stall_flush", stall_o, 0);
    tick(); if_flush_i = 1'b0;
    chk("t3_cyc_kept", bus_cyc_o, 1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h55;
    tick(); bus_ack_i = 1'b0;
    chk("t3_suppressed", {if_done_o, bus_cyc_o}, 0);
    if_addr_i = 32'h10C;
    tick();
    tick();
    chk("t3_next_addr", {bus_cyc_o, bus_addr_o}, {1'b1, 32'h10C});
    bus_ack_i = 1'b1; bus_rdata_i = 32'h66;
    tick(); bus_ack_i = 1'b0;
    chk("t3_next_done", if_done_o, 1);
    chk("t3_next_rdata", if_rdata_o, 32'h66);
    if_req_i = 1'b0;
    tick();
    // 4: reset in DATA_BUSY, late ack ignored
    data_req_i = 1'b1; data_addr_i = 32'h400;
    tick();
    chk("t4_busy", bus_cyc_o, 1);
    rst = 1'b1; #1;
    chk("t4_rst_cyc", bus_cyc_o, 0);
    chk("t4_rst_stall", stall_o, 0);
    data_req_i = 1'b0;
    tick(); rst = 1'b0;
    bus_ack_i = 1'b1; bus_rdata_i = 32'hBAD;
    tick();
    chk("t4_late_ack", {bus_cyc_o, data_done_o, if_done_o}, 0);
    tick(); bus_ack_i = 1'b0;
    chk("t4_late_ack2", {data_done_o, data_rdata_o}, 0);
    // 6: back-to-back data reads
    data_req_i = 1'b1; data_addr_i = 32'h300;
    tick();
    chk("t6_addr0", bus_addr_o, 32'h300);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h300A;
    tick(); bus_ack_i = 1'b0;
    chk("t6_done0", data_done_o, 1);
    chk("t6_rdata0", data_rdata_o, 32'h300A);
    data_addr_i = 32'h304;
    tick();
    chk("t6_gap1", {data_done_o, stall_o}, {1'b0, 6'b011111});
    tick();
    chk("t6_gap2", {data_done_o, bus_addr_o}, {1'b0, 32'h304});
    bus_ack_i = 1'b1; bus_rdata_i = 32'h304B;
    tick(); bus_ack_i = 1'b0;
    chk("t6_done1", data_done_o, 1);
    chk("t6_rdata1", data_rdata_o, 32'h304B);
    data_req_i = 1'b0;
    tick();
`ifdef BUS_TIMEOUT_EN
    // 5: timeout after four busy cycles without ack
    data_req_i = 1'b1; data_addr_i = 32'h500;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t5_wait", {bus_cyc_o, data_done_o}, 2'b10);
      tick();
    end
    chk("t5_last_busy", bus_cyc_o, 1);
    tick();
    chk("t5_err", {data_done_o, data_err_o, bus_cyc_o}, 3'b110);
    chk("t5_rdata_kept", data_rdata_o, 32'h304B);
    data_req_i = 1'b0;
    tick();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
